// File: rtl/segment_bank_file.sv
// segment_bank_file: a bank of segment registers with two byte-masked write
// ports (A highest priority, B lowest) and a single deferred-write slot that
// is loaded with d_we and applied to its target register on commit.
module segment_bank_file #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter logic [NUM_REGS*WIDTH-1:0] RESET_VALUES = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000}
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          a_we,
  input  logic [$clog2(NUM_REGS)-1:0]   a_id,
  input  logic [WIDTH/8-1:0]            a_be,
  input  logic [WIDTH-1:0]              a_data,
  input  logic                          b_we,
  input  logic [$clog2(NUM_REGS)-1:0]   b_id,
  input  logic [WIDTH/8-1:0]            b_be,
  input  logic [WIDTH-1:0]              b_data,
  input  logic                          d_we,
  input  logic [$clog2(NUM_REGS)-1:0]   d_id,
  input  logic [WIDTH-1:0]              d_data,
  input  logic                          commit,
  output logic [NUM_REGS*WIDTH-1:0]     registers,
  output logic                          pending_valid,
  output logic [$clog2(NUM_REGS)-1:0]   pending_id,
  output logic                          bad_id
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned NB = WIDTH / 8;

  typedef enum logic {PEND_EMPTY, PEND_FULL} pend_state_e;

  pend_state_e               state_q, state_d;
  logic [IW-1:0]             pend_id_q, pend_id_d;
  logic [WIDTH-1:0]          pend_data_q, pend_data_d;
  logic [NUM_REGS*WIDTH-1:0] regs_q, regs_d;
  logic                      bad_id_q, bad_id_d;
  logic                      d_load;
  logic                      commit_fire;

  // Index range checks: an out-of-range enabled port is ignored and flagged.
  always_comb begin
    bad_id_d = (a_we && !(32'(a_id) < NUM_REGS)) ||
               (b_we && !(32'(b_id) < NUM_REGS)) ||
               (d_we && !(32'(d_id) < NUM_REGS));
    d_load   = d_we && (32'(d_id) < NUM_REGS);
  end

  // Pending-slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PEND_EMPTY;
    else          state_q <= state_d;
  end

  // Pending-slot next state: a valid load always leaves the slot full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PEND_EMPTY: if (d_load) state_d = PEND_FULL;
      PEND_FULL:  if (d_load) state_d = PEND_FULL;
                  else if (commit) state_d = PEND_EMPTY;
      default:    state_d = PEND_EMPTY;
    endcase
  end

  // Pending-slot outputs: occupancy and whether a commit actually applies.
  always_comb begin
    pending_valid = (state_q == PEND_FULL);
    commit_fire   = commit && (state_q == PEND_FULL);
  end

  // Pending-slot payload: captured on a valid load, otherwise held.
  always_comb begin
    pend_id_d   = d_load ? d_id   : pend_id_q;
    pend_data_d = d_load ? d_data : pend_data_q;
  end

  // Per register, per byte lane write select with priority A > commit > B.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      for (int unsigned l = 0; l < NB; l++) begin
        if (a_we && a_id == IW'(i) && a_be[l])
          regs_d[i*WIDTH + l*8 +: 8] = a_data[l*8 +: 8];
        else if (commit_fire && pend_id_q == IW'(i))
          regs_d[i*WIDTH + l*8 +: 8] = pend_data_q[l*8 +: 8];
        else if (b_we && b_id == IW'(i) && b_be[l])
          regs_d[i*WIDTH + l*8 +: 8] = b_data[l*8 +: 8];
      end
    end
  end

  // Register bank, pending payload and bad-index pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q      <= RESET_VALUES;
      pend_id_q   <= '0;
      pend_data_q <= '0;
      bad_id_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pend_id_q   <= pend_id_d;
      pend_data_q <= pend_data_d;
      bad_id_q    <= bad_id_d;
    end
  end

  assign registers  = regs_q;
  assign pending_id = pend_id_q;
  assign bad_id     = bad_id_q;

endmodule

// File: tb/tb_segment_bank_file.sv
// Bench for segment_bank_file: one 4-register and one 3-register instance share
// the same stimulus; each is checked every cycle against a behavioural model.
module tb_segment_bank_file;

  typedef struct packed {
    logic        awe; logic [1:0] aid; logic [1:0] abe; logic [15:0] ad;
    logic        bwe; logic [1:0] bid; logic [1:0] bbe; logic [15:0] bd;
    logic        dwe; logic [1:0] did; logic [15:0] dd;
    logic        cm;
  } in_t;

  typedef struct packed {
    logic [3:0][15:0] r;
    logic             pv;
    logic [1:0]       pid;
    logic [15:0]      pd;
    logic             bad;
  } mst_t;

  localparam logic [63:0] RV4 = 64'h0000_0000_FFFF_0000;
  localparam logic [47:0] RV3 = 48'hA5A5_00FF_1234;

  logic  clk = 1'b0;
  logic  reset_n;
  in_t   cur;
  mst_t  m4, m3;
  int    errors = 0;
  int    checks = 0;
  bit    run = 1'b0;

  logic [63:0] regs4; logic pv4; logic [1:0] pid4; logic bad4;
  logic [47:0] regs3; logic pv3; logic [1:0] pid3; logic bad3;

  always #5 clk = ~clk;

  segment_bank_file #(.NUM_REGS(4), .WIDTH(16), .RESET_VALUES(RV4)) u4 (
    .clk(clk), .reset_n(reset_n),
    .a_we(cur.awe), .a_id(cur.aid), .a_be(cur.abe), .a_data(cur.ad),
    .b_we(cur.bwe), .b_id(cur.bid), .b_be(cur.bbe), .b_data(cur.bd),
    .d_we(cur.dwe), .d_id(cur.did), .d_data(cur.dd), .commit(cur.cm),
    .registers(regs4), .pending_valid(pv4), .pending_id(pid4), .bad_id(bad4)
  );

  segment_bank_file #(.NUM_REGS(3), .WIDTH(16), .RESET_VALUES(RV3)) u3 (
    .clk(clk), .reset_n(reset_n),
    .a_we(cur.awe), .a_id(cur.aid), .a_be(cur.abe), .a_data(cur.ad),
    .b_we(cur.bwe), .b_id(cur.bid), .b_be(cur.bbe), .b_data(cur.bd),
    .d_we(cur.dwe), .d_id(cur.did), .d_data(cur.dd), .commit(cur.cm),
    .registers(regs3), .pending_valid(pv3), .pending_id(pid3), .bad_id(bad3)
  );

  function automatic mst_t rst_state(logic [63:0] rv);
    mst_t s;
    s   = '0;
    s.r = rv;
    return s;
  endfunction

  // Model of one clock edge: lanes are written lowest priority first so that
  // higher-priority sources simply overwrite them.
  function automatic mst_t step(mst_t s, in_t x, int n);
    mst_t ns;
    bit   fire;
    ns     = s;
    fire   = x.cm && s.pv;
    ns.bad = (x.awe && x.aid >= n) || (x.bwe && x.bid >= n) || (x.dwe && x.did >= n);
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < 2; l++) begin
        if (x.bwe && x.bid == i && x.bbe[l]) ns.r[i][l*8 +: 8] = x.bd[l*8 +: 8];
        if (fire && s.pid == i)              ns.r[i][l*8 +: 8] = s.pd[l*8 +: 8];
        if (x.awe && x.aid == i && x.abe[l]) ns.r[i][l*8 +: 8] = x.ad[l*8 +: 8];
      end
    end
    if (x.dwe && x.did < n) begin
      ns.pv  = 1'b1;
      ns.pid = x.did;
      ns.pd  = x.dd;
    end else if (fire) begin
      ns.pv  = 1'b0;
    end
    return ns;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t wr(bit port_b, logic [1:0] id, logic [1:0] be, logic [15:0] d);
    in_t x;
    x = '0;
    if (port_b) begin x.bwe = 1'b1; x.bid = id; x.bbe = be; x.bd = d; end
    else        begin x.awe = 1'b1; x.aid = id; x.abe = be; x.ad = d; end
    return x;
  endfunction

  // Every-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (run) begin
      chk("regs4", regs4, m4.r);
      chk("pv4",   64'(pv4),  64'(m4.pv));
      chk("pid4",  64'(pid4), 64'(m4.pid));
      chk("bad4",  64'(bad4), 64'(m4.bad));
      chk("regs3", {16'h0, regs3}, {16'h0, m3.r[2], m3.r[1], m3.r[0]});
      chk("pv3",   64'(pv3),  64'(m3.pv));
      chk("pid3",  64'(pid3), 64'(m3.pid));
      chk("bad3",  64'(bad3), 64'(m3.bad));
    end
  end

  task automatic cycle(in_t x);
    cur = x;
    @(posedge clk);
    if (reset_n) begin
      m4 = step(m4, x, 4);
      m3 = step(m3, x, 3);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    cur = '0;
    m4 = rst_state(RV4);
    m3 = rst_state({16'h0, RV3});
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    in_t x;
    reset_n = 1'b1;
    cur = '0;
    m4 = rst_state(RV4);
    m3 = rst_state({16'h0, RV3});
    #1 reset_n = 1'b0;
    run = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Reset image.
    chk("rst_regs4", regs4, 64'h0000_0000_FFFF_0000);
    chk("rst_pv4",   64'(pv4), 64'h0);
    chk("rst_bad4",  64'(bad4), 64'h0);
    chk("rst_regs3", {16'h0, regs3}, 64'h0000_A5A5_00FF_1234);

    // Byte-lane writes from A then B.
    cycle(wr(1'b0, 2'd2, 2'b01, 16'h1234));
    chk("a_lane_reg2", 64'(regs4[47:32]), 64'h0034);
    cycle(wr(1'b1, 2'd2, 2'b10, 16'hAB00));
    chk("b_lane_reg2", 64'(regs4[47:32]), 64'hAB34);

    // A and B collide on reg0.
    x = wr(1'b0, 2'd0, 2'b01, 16'h0011);
    x.bwe = 1'b1; x.bid = 2'd0; x.bbe = 2'b11; x.bd = 16'h2222;
    cycle(x);
    chk("ab_reg0", 64'(regs4[15:0]), 64'h2211);

    // Deferred write, commit, redundant commit.
    x = '0; x.dwe = 1'b1; x.did = 2'd3; x.dd = 16'h5555;
    cycle(x);
    chk("defer_pv",   64'(pv4), 64'h1);
    chk("defer_pid",  64'(pid4), 64'h3);
    chk("defer_reg3", 64'(regs4[63:48]), 64'h0000);
    x = '0; x.cm = 1'b1;
    cycle(x);
    chk("commit_reg3", 64'(regs4[63:48]), 64'h5555);
    chk("commit_pv",   64'(pv4), 64'h0);
    cycle(x);
    chk("recommit_reg3", 64'(regs4[63:48]), 64'h5555);
    chk("recommit_pv",   64'(pv4), 64'h0);

    // Commit beats B, concurrent reload keeps the slot full.
    x = '0; x.dwe = 1'b1; x.did = 2'd1; x.dd = 16'h7777;
    cycle(x);
    x = wr(1'b1, 2'd1, 2'b11, 16'h0101);
    x.cm = 1'b1; x.dwe = 1'b1; x.did = 2'd0; x.dd = 16'h9999;
    cycle(x);
    chk("cb_reg1", 64'(regs4[31:16]), 64'h7777);
    chk("cb_pv",   64'(pv4), 64'h1);
    chk("cb_pid",  64'(pid4), 64'h0);

    // Out-of-range index on the 3-register instance.
    do_reset();
    cycle(wr(1'b0, 2'd3, 2'b11, 16'hBEEF));
    chk("bad_regs3", {16'h0, regs3}, 64'h0000_A5A5_00FF_1234);
    chk("bad_pulse", 64'(bad3), 64'h1);
    cycle('0);
    chk("bad_clear", 64'(bad3), 64'h0);

    // Asynchronous reset while the slot is full.
    x = '0; x.dwe = 1'b1; x.did = 2'd2; x.dd = 16'h4444;
    cycle(x);
    chk("full_pv3", 64'(pv3), 64'h1);
    #2;
    reset_n = 1'b0;
    cur = '0;
    m4 = rst_state(RV4);
    m3 = rst_state({16'h0, RV3});
    #1;
    chk("async_pv3",   64'(pv3), 64'h0);
    chk("async_pv4",   64'(pv4), 64'h0);
    chk("async_regs4", regs4, 64'h0000_0000_FFFF_0000);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with occasional mid-run resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        x     = '0;
        x.awe = ($urandom_range(0, 2) == 0);
        x.aid = 2'($urandom);
        x.abe = 2'($urandom);
        x.ad  = 16'($urandom);
        x.bwe = ($urandom_range(0, 1) == 0);
        x.bid = 2'($urandom);
        x.bbe = 2'($urandom);
        x.bd  = 16'($urandom);
        x.dwe = ($urandom_range(0, 3) == 0);
        x.did = 2'($urandom);
        x.dd  = 16'($urandom);
        x.cm  = ($urandom_range(0, 2) == 0);
        cycle(x);
      end
    end

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segment_bank_file.md
SEGMENT_BANK_FILE -- requirements
Module: segment_bank_file

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of segment registers (2..16).
REQ-002 SHALL have parameter WIDTH, default 16, register width in bits (multiple of 8, 8..32).
REQ-003 SHALL have parameter RESET_VALUES, default {16'h0000,16'h0000,16'hFFFF,16'h0000} (reg0 in LSBs), packed NUM_REGS*WIDTH reset image.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port a_we  in  1  write port A enable (highest priority).
REQ-007 SHALL have port a_id  in  $clog2(NUM_REGS)  port A target index.
REQ-008 SHALL have port a_be  in  WIDTH/8  port A byte enables.
REQ-009 SHALL have port a_data  in  WIDTH  port A write data.
REQ-010 SHALL have ports b_we, b_id, b_be, b_data, identical in form to port A, forming write port B (lowest priority).
REQ-011 SHALL have port d_we  in  1  deferred-write request (load pending slot).
REQ-012 SHALL have port d_id  in  $clog2(NUM_REGS)  deferred target index.
REQ-013 SHALL have port d_data  in  WIDTH  deferred data, full width.
REQ-014 SHALL have port commit  in  1  apply pending slot to its target.
REQ-015 SHALL have port registers  out  NUM_REGS*WIDTH  current register contents, reg0 in LSBs.
REQ-016 SHALL have port pending_valid  out  1  pending slot occupied.
REQ-017 SHALL have port pending_id  out  $clog2(NUM_REGS)  pending target index.
REQ-018 SHALL have port bad_id  out  1  one-cycle pulse, out-of-range index used.

Function
REQ-019 All writes SHALL take effect on the rising clk edge after the request; registers SHALL reflect them with zero additional latency (direct register outputs, no read mux).
REQ-020 Port A/B write SHALL update only byte lanes with be bit set; be=0 SHALL leave the register unchanged.
REQ-021 Per register, per byte lane, priority SHALL be port A > commit > port B.
REQ-022 A and B to the same id, same cycle: lanes enabled by A take A data; lanes enabled only by B take B data.
REQ-023 d_we=1 SHALL load pending slot (id, data) and set pending_valid=1 next cycle; registers unchanged by d_we alone.
REQ-024 commit=1 with pending_valid=1 SHALL write the full pending data to register pending_id and clear pending_valid, subject to REQ-021.
REQ-025 commit=1 with pending_valid=0 SHALL be a no-op.
REQ-026 commit and d_we same cycle SHALL commit the old pending contents and load the new request; pending_valid stays 1.
REQ-027 d_we while pending_valid=1 without commit SHALL overwrite the pending slot (old deferred value lost).
REQ-028 Any index >= NUM_REGS on an enabled port (a_we, b_we, d_we) SHALL be ignored for that port and pulse bad_id high for exactly the following cycle; d_we with bad id SHALL not alter the pending slot.
REQ-029 Write port behaviour SHALL not depend on pending state; pending_id equal to an A/B target causes no hazard beyond REQ-021.
REQ-030 Pending slot SHALL be a two-state machine: EMPTY -> FULL on d_we; FULL -> EMPTY on commit without d_we; FULL -> FULL on d_we (with or without commit).

Reset
REQ-031 reset_n=0 SHALL immediately (asynchronously) set register i to RESET_VALUES[i*WIDTH +: WIDTH], pending_valid=0, pending_id=0, pending data=0, bad_id=0.
REQ-032 Reset asserted mid-operation SHALL discard pending slot and all same-cycle writes; deassertion SHALL take effect synchronously with no write occurring on the deassertion edge itself unless requested.

Verification
REQ-033 Default params, reset pulse -> registers=0x0000_0000_FFFF_0000, pending_valid=0, bad_id=0.
REQ-034 a_we id=2 be=2'b01 data=0x1234 -> reg2=0x0034; then b_we id=2 be=2'b10 data=0xAB00 -> reg2=0xAB34.
REQ-035 Same cycle a_we id=0 be=01 data=0x0011 and b_we id=0 be=11 data=0x2222 -> reg0=0x2211.
REQ-036 d_we id=3 data=0x5555 -> pending_valid=1, pending_id=3, reg3 unchanged; commit -> reg3=0x5555, pending_valid=0; commit again -> no change.
REQ-037 Pending id=1 data=0x7777; same cycle commit, b_we id=1 be=11 data=0x0101, d_we id=0 data=0x9999 -> reg1=0x7777, pending_valid=1, pending_id=0.
REQ-038 NUM_REGS=3, a_we id=3 -> no register change, bad_id=1 for one cycle; reset_n low during FULL pending -> pending_valid=0 without clock edge.
